// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with fixed-latency reads
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    output logic        mem_we,
    input  logic [31:0] mem_data_in,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic        r_ptr;
    logic        r_id;
    logic        r_we;

    logic        w_take;
    logic        w_sel;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_done;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_out;
    logic        r_mem_we;
    logic        r_busy;

    // Arbitration: a lone requester always wins; on contention the pointer decides
    always_comb begin
        w_take      = 1'b0;
        w_sel       = 1'b0;
        if (r_state == ST_IDLE && (req0 || req1)) begin
            w_take = 1'b1;
            w_sel  = (req0 && req1) ? r_ptr : req1;
        end
        w_sel_we    = w_sel ? we1    : we0;
        w_sel_addr  = w_sel ? addr1  : addr0;
        w_sel_wdata = w_sel ? wdata1 : wdata0;
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_we) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_done       = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, capture registers and registered outputs; outputs are computed one
    // edge early so they are valid during the ISSUE / DONE cycle itself
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 2'd0;
            r_ptr          <= 1'b0;
            r_id           <= 1'b0;
            r_we           <= 1'b0;
            r_gnt0         <= 1'b0;
            r_gnt1         <= 1'b0;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_rdata0       <= 32'd0;
            r_rdata1       <= 32'd0;
            r_mem_address  <= 32'd0;
            r_mem_data_out <= 32'd0;
            r_mem_we       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_gnt0    <= w_take && !w_sel;
            r_gnt1    <= w_take && w_sel;
            r_mem_we  <= w_take && w_sel_we;
            r_rvalid0 <= w_done && !r_id;
            r_rvalid1 <= w_done && r_id;
            if (w_take) begin
                r_id           <= w_sel;
                r_we           <= w_sel_we;
                r_mem_address  <= w_sel_addr;
                r_mem_data_out <= w_sel_wdata;
            end
            // Pointer moves only when the grant is actually issued
            if (r_state == ST_ISSUE) begin
                r_ptr <= !r_id;
            end
            if (w_done && !r_id) begin
                r_rdata0 <= mem_data_in;
            end
            if (w_done && r_id) begin
                r_rdata1 <= mem_data_in;
            end
        end
    end

    assign gnt0         = r_gnt0;
    assign gnt1         = r_gnt1;
    assign rvalid0      = r_rvalid0;
    assign rvalid1      = r_rvalid1;
    assign rdata0       = r_rdata0;
    assign rdata1       = r_rdata1;
    assign mem_address  = r_mem_address;
    assign mem_data_out = r_mem_data_out;
    assign mem_we       = r_mem_we;
    assign busy         = r_busy;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, memory read latency in cycles (legal 1..4), counted from the ISSUE cycle to the cycle in which mem_data_in is valid.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req0/req1  input  1  access request, requester 0 (core) / 1 (loader).
REQ-005 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports addr0/addr1  input  32  byte address.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted and issued.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse: rdata valid.
REQ-010 SHALL have ports rdata0/rdata1  output  32  read data.
REQ-011 SHALL have port mem_address  output  32  address to memory.
REQ-012 SHALL have port mem_data_out  output  32  write data to memory.
REQ-013 SHALL have port mem_we  output  1  memory write enable.
REQ-014 SHALL have port mem_data_in  input  32  read data from memory.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-017 In IDLE, a sampled request SHALL be captured (we, addr, wdata, requester id) and the FSM SHALL move to ISSUE on the next edge; with no request it SHALL stay in IDLE.
REQ-018 When req0 and req1 are both high in IDLE, the grant SHALL go to the requester not granted last (round-robin pointer); the pointer SHALL be 0 after reset, giving requester 0 priority first.
REQ-019 A single requesting agent SHALL always be granted, regardless of the pointer; the pointer SHALL update only on a grant.
REQ-020 In ISSUE, for exactly one cycle:
  - the captured address and data SHALL drive mem_address / mem_data_out;
  - mem_we SHALL equal the captured we;
  - the gnt of the captured requester SHALL be 1.
REQ-021 ISSUE exit:
  - write: SHALL go to IDLE;
  - read: SHALL go to WAIT, loading a counter with LATENCY-1.
REQ-022 WAIT SHALL decrement the counter each cycle; at counter 0 it SHALL capture mem_data_in and go to DONE (LATENCY=1 gives one WAIT cycle).
REQ-023 In DONE, for one cycle, the captured requester's rvalid SHALL be 1 and its rdata SHALL hold the captured value; the FSM SHALL then go to IDLE.
REQ-024 Read latency SHALL be LATENCY+2 cycles from the request-sampled edge to rvalid.
REQ-025 Write latency SHALL be 1 cycle from the request-sampled edge to gnt.
REQ-026 Minimum spacing SHALL be one IDLE cycle between transactions; no pipelining of requests.
REQ-027 Requesters SHALL hold req/we/addr/wdata until their gnt; req changes after capture SHALL NOT cancel or alter the transaction.
REQ-028 A request to the non-owning requester while busy SHALL wait and be arbitrated on the next IDLE cycle.
REQ-029 rdataN SHALL hold its value until the next read response to that requester.
REQ-030 mem_we SHALL be 0 outside ISSUE; mem_address and mem_data_out SHALL hold their last issued values outside ISSUE.
REQ-031 gnt0 and gnt1 SHALL never be high together, and rvalid0 and rvalid1 SHALL never be high together.

Reset
REQ-032 With resetn=0 at an edge, the block SHALL enter IDLE with pointer=0, counter=0, busy=0, gnt0/1=0, rvalid0/1=0, mem_we=0, mem_address=0, mem_data_out=0, rdata0/1=0.
REQ-033 Reset in any state, including mid-read in WAIT, SHALL abort the transaction with no gnt or rvalid emitted and mem_we=0 from the next cycle.
REQ-034 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-035 LATENCY=1, read req0 at addr 0x10 with mem returning 0xDEADBEEF -> gnt0 1 cycle later; mem_address=0x10, mem_we=0; rvalid0 with rdata0=0xDEADBEEF 3 cycles after the request edge.
REQ-036 Write req1 at addr 0x20 with data 0x1234 -> one cycle with mem_we=1, mem_address=0x20, mem_data_out=0x1234, gnt1=1; busy back to 0 the next cycle; no rvalid.
REQ-037 req0 and req1 both held high, reads, for 4 grants from reset -> grant order 0,1,0,1; never both gnt high.
REQ-038 LATENCY=4, read -> exactly 4 WAIT cycles; rvalid 6 cycles after the request edge; rdata equals mem_data_in on the last WAIT cycle.
REQ-039 resetn=0 during WAIT -> next cycle busy=0 and all outputs at reset values; no rvalid ever for the aborted read; a following request is served normally with pointer=0.
REQ-040 req0 dropped the cycle after capture -> transaction completes: gnt0, then rvalid0.
